// File: rtl/ring_read_addr_gen.sv
// rtl/ring_read_addr_gen.sv - read-side address generator for a circular sample RAM
// Tracks the free-running writer by counting wr_en and serves reads once the fill threshold is met.
module ring_read_addr_gen #(
    parameter int BIT_SZ = 10,
    parameter int THRESH = 512
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clear,
    input  logic              wr_en,
    input  logic              rd_req,
    output logic [BIT_SZ-1:0] rd_addr,
    output logic              rd_valid,
    output logic [BIT_SZ:0]   level,
    output logic [1:0]        state,
    output logic              underflow,
    output logic              overflow
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    localparam logic [BIT_SZ:0] FULL     = {1'b1, {BIT_SZ{1'b0}}};
    localparam logic [BIT_SZ:0] THRESH_L = (BIT_SZ+1)'(THRESH);
    localparam logic [BIT_SZ:0] ONE      = (BIT_SZ+1)'(1);

    state_t          state_q;
    state_t          state_d;
    logic [BIT_SZ:0] level_d;
    logic            full;
    logic            empty;
    logic            rd_acc;
    logic            rd_rej;
    logic            ovf_hit;

    assign full    = (level == FULL);
    assign empty   = (level == '0);
    assign rd_acc  = (state_q == ST_RUN) && rd_req && !empty;
    assign rd_rej  = (state_q == ST_RUN) && rd_req && empty;
    // A write into a full buffer overwrites the oldest word, so the reader skips past it.
    assign ovf_hit = wr_en && full && !rd_acc;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (wr_en) state_d = ST_FILL;
            ST_FILL: if (level >= THRESH_L) state_d = ST_RUN;
            ST_RUN:  if (rd_rej) state_d = ST_FILL;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        level_d = level;
        if (wr_en && !rd_acc && !full) begin
            level_d = level + ONE;
        end else if (rd_acc && !wr_en) begin
            level_d = level - ONE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            rd_addr   <= '0;
            rd_valid  <= 1'b0;
            level     <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state_q   <= ST_IDLE;
            rd_addr   <= '0;
            rd_valid  <= 1'b0;
            level     <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q  <= state_d;
            level    <= level_d;
            rd_valid <= rd_acc;
            if (rd_acc || ovf_hit) begin
                rd_addr <= rd_addr + 1'b1;
            end
            if (rd_rej) begin
                underflow <= 1'b1;
            end
            if (ovf_hit) begin
                overflow <= 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_ring_read_addr_gen.sv
// tb/tb_ring_read_addr_gen.sv - scoreboard bench for ring_read_addr_gen with a behavioural buffer model
// The model treats the buffer as a queue of written words; addresses derive from write totals.
module tb_ring_read_addr_gen;
    localparam int BIT_SZ = 10;
    localparam int THRESH = 512;
    localparam int DEPTH  = 1 << BIT_SZ;

    logic              clock;
    logic              resetn;
    logic              clear;
    logic              wr_en;
    logic              rd_req;
    logic [BIT_SZ-1:0] rd_addr;
    logic              rd_valid;
    logic [BIT_SZ:0]   level;
    logic [1:0]        state;
    logic              underflow;
    logic              overflow;

    ring_read_addr_gen #(.BIT_SZ(BIT_SZ), .THRESH(THRESH)) dut (
        .clock(clock),
        .resetn(resetn),
        .clear(clear),
        .wr_en(wr_en),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_valid(rd_valid),
        .level(level),
        .state(state),
        .underflow(underflow),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sample RAM and writer owned by the bench
    logic [15:0]       mem [0:DEPTH-1];
    logic [15:0]       ram_q;
    logic [15:0]       din;
    logic [BIT_SZ-1:0] wp;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) wp <= '0;
        else if (clear) wp <= '0;
        else if (wr_en) begin
            mem[wp] <= din;
            wp <= wp + 1'b1;
        end
    end

    always @(posedge clock) ram_q <= mem[rd_addr];

    typedef struct {
        logic [BIT_SZ-1:0] addr;
        logic              valid;
        logic [BIT_SZ:0]   lvl;
        logic [1:0]        st;
        logic              uf;
        logic              of;
    } snap_t;

    snap_t       exp_q[$];
    logic [15:0] rdq[$];
    logic [15:0] data_q[$];
    snap_t       e;

    int checks   = 0;
    int failures = 0;

    int m_wr_total = 0;
    int m_state    = 0;
    bit m_uf       = 0;
    bit m_of       = 0;
    bit m_valid    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_addr", 32'(rd_addr), 32'(e.addr));
            chk("rd_valid", 32'(rd_valid), 32'(e.valid));
            chk("level", 32'(level), 32'(e.lvl));
            chk("state", 32'(state), 32'(e.st));
            chk("underflow", 32'(underflow), 32'(e.uf));
            chk("overflow", 32'(overflow), 32'(e.of));
        end
        if (resetn && rd_valid) begin
            if (rdq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_data unexpected rd_valid actual=1 expected=0 t=%0t", $time);
            end else begin
                chk("rd_data", 32'(ram_q), 32'(rdq.pop_front()));
            end
        end
    end

    task automatic model_reset();
        data_q.delete();
        m_wr_total = 0;
        m_state    = 0;
        m_uf       = 0;
        m_of       = 0;
        m_valid    = 0;
    endtask

    task automatic step(input bit w, input bit r, input bit c);
        int    lvl0;
        bit    acc;
        bit    rej;
        snap_t s;
        @(negedge clock);
        wr_en  = w;
        rd_req = r;
        clear  = c;
        din    = 16'(m_wr_total * 7 + 3);
        lvl0   = data_q.size();
        if (c) begin
            model_reset();
        end else begin
            acc = (m_state == 2) && r && (lvl0 > 0);
            rej = (m_state == 2) && r && (lvl0 == 0);
            if (acc) rdq.push_back(data_q.pop_front());
            if (w) begin
                if (data_q.size() == DEPTH) begin
                    data_q.delete(0);
                    m_of = 1;
                end
                data_q.push_back(din);
                m_wr_total++;
            end
            m_valid = acc;
            if (rej) m_uf = 1;
            case (m_state)
                0: if (w) m_state = 1;
                1: if (lvl0 >= THRESH) m_state = 2;
                2: if (rej) m_state = 1;
                default: m_state = 0;
            endcase
        end
        s.addr  = BIT_SZ'((m_wr_total - data_q.size()) % DEPTH);
        s.valid = m_valid;
        s.lvl   = (BIT_SZ+1)'(data_q.size());
        s.st    = 2'(m_state);
        s.uf    = m_uf;
        s.of    = m_of;
        exp_q.push_back(s);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_underflow"}, 32'(underflow), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    task automatic async_reset();
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check_reset_values("async_rst");
        exp_q.delete();
        rdq.delete();
        model_reset();
        @(negedge clock);
        wr_en  = 1'b0;
        rd_req = 1'b0;
        clear  = 1'b0;
        resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int pw;
        int pr;
        resetn = 1'b0;
        clear  = 1'b0;
        wr_en  = 1'b0;
        rd_req = 1'b0;
        din    = '0;
        #23;
        check_reset_values("por");
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 3; i++) step(0, 1, 0);
        for (int i = 0; i < 512; i++) step(1, 1'($urandom % 2), 0);
        step(0, 1, 0);
        step(0, 0, 0);
        for (int i = 0; i < 512; i++) step(1, 0, 0);
        for (int i = 0; i < 1100; i++) step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        for (int i = 0; i < 1030; i++) step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 512; i++) step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);

        for (int k = 0; k < 8; k++) begin
            pw = int'($urandom_range(20, 90));
            pr = int'($urandom_range(20, 90));
            for (int i = 0; i < 400; i++)
                step(1'(($urandom % 100) < pw), 1'(($urandom % 100) < pr), 1'(($urandom % 700) == 0));
        end

        step(0, 0, 1);
        for (int i = 0; i < 512; i++) step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 212; i++) step(0, 1, 0);
        async_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        step(0, 0, 0);
        repeat (3) @(posedge clock);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
